// File: rtl/piso_pkg.sv
// Shared state encoding for the piso_tx serializer.
// PISO_TX_PARITY_EN adds the PARITY state to the encoding.
package piso_pkg;

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit counter for piso_tx: synchronous clear, enable-gated increment,
// asynchronous active-low reset.
module piso_bit_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       clear,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with registered serial outputs.
// Define PISO_TX_PARITY_EN to append an even-parity bit to each frame.
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last
);

  localparam int unsigned CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH-1);
  localparam logic [CW-1:0] PENULT_IDX = CW'(WIDTH-2);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             accept;
  logic             cnt_en;
`ifdef PISO_TX_PARITY_EN
  logic             par;
`endif

  assign load_ready = (state == IDLE) && en;
  assign accept     = load_valid && load_ready;
  assign cnt_en     = en && (state == SHIFT);

  function automatic logic head(input logic [WIDTH-1:0] x);
    return MSB_FIRST ? x[WIDTH-1] : x[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] x);
    return MSB_FIRST ? (x << 1) : (x >> 1);
  endfunction

  piso_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clear (accept),
    .count (count)
  );

  // count holds the index of the bit currently on sout; the first bit is
  // presented on the accept edge, so shreg is loaded already advanced.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else if (en) begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            state      <= SHIFT;
            shreg      <= advance(load_data);
            sout       <= head(load_data);
            sout_valid <= 1'b1;
            sout_last  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par        <= ^load_data;
`endif
          end
        end
        SHIFT: begin
          if (count == LAST_IDX) begin
`ifdef PISO_TX_PARITY_EN
            state      <= PARITY;
            sout       <= par;
            sout_last  <= 1'b1;
`else
            state      <= IDLE;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
`endif
          end else begin
            sout  <= head(shreg);
            shreg <= advance(shreg);
`ifdef PISO_TX_PARITY_EN
            sout_last <= 1'b0;
`else
            sout_last <= (count == PENULT_IDX);
`endif
          end
        end
`ifdef PISO_TX_PARITY_EN
        PARITY: begin
          state      <= IDLE;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          sout_last  <= 1'b0;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the number of data bits per word (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port en  input  1  synchronous clock enable; 0 freezes all state.
REQ-006 SHALL have port load_valid  input  1  a parallel word is offered on load_data.
REQ-007 SHALL have port load_data  input  WIDTH  the parallel word to serialize.
REQ-008 SHALL have port load_ready  output  1  combinational; equals 1 only when state is IDLE and en is 1.
REQ-009 SHALL have port sout  output  1  registered serial data bit.
REQ-010 SHALL have port sout_valid  output  1  registered; sout carries a frame bit.
REQ-011 SHALL have port sout_last  output  1  registered; marks the final bit of a frame.

Function
REQ-012 SHALL implement states IDLE and SHIFT, plus PARITY when the parity feature is compiled in.
REQ-013 SHALL accept a word on a rising edge where load_valid, load_ready and en are all 1.
REQ-014 SHALL, on acceptance, copy load_data into a shift register, move to SHIFT, and present the first bit on sout with sout_valid=1 from that same edge.
REQ-015 SHALL present exactly one new bit per rising edge with en=1 while in SHIFT, in MSB_FIRST order.
REQ-016 SHALL count bits with a counter of width $clog2(WIDTH+1), cleared on acceptance.
REQ-017 SHALL assert sout_last together with the final frame bit and return to IDLE on the next en edge.
REQ-018 SHALL, on that return edge, drive sout_valid=0, sout_last=0 and sout=0, even if a new word is waiting.
REQ-019 SHALL ignore load_valid and load_data outside IDLE; no word is queued.
REQ-020 SHALL, on an edge with en=0, hold state, counter, shift register and all registered outputs unchanged.
REQ-021 SHALL, when en=0, drive load_ready=0, so that no handshake occurs.
REQ-022 SHALL send a frame of WIDTH bits (WIDTH+1 with parity) that occupies exactly that many en=1 cycles; minimum spacing between accepted words is frame length + 1 en-cycles.

Reset
REQ-023 SHALL, while reset=0, force state=IDLE, counter=0, shift register=0, sout=0, sout_valid=0 and sout_last=0, independent of clk and en.
REQ-024 SHALL abort a frame when reset is asserted mid-frame; the partial frame is discarded and not resumed.
REQ-025 SHALL accept a word on the first en edge after reset deasserts, if load_valid=1.

Configuration
REQ-026 SHALL, when macro PISO_TX_PARITY_EN is defined, append one even-parity bit (XOR of all WIDTH data bits) after the data bits; only that bit carries sout_last.
REQ-027 SHALL, when PISO_TX_PARITY_EN is undefined, contain no PARITY state or parity logic, and the frame is exactly WIDTH bits.

Structure
REQ-028 SHALL place the state encoding localparams (IDLE, SHIFT, PARITY) in shared package piso_pkg.
REQ-029 SHALL implement the bit counter as sub-module piso_bit_cnt, with inputs clk, reset, en, clear and output count.

Verification
REQ-030 SHALL cover reset: reset=0 mid-frame -> sout=0, sout_valid=0, sout_last=0 and load_ready=1 (with en=1) within the same time step.
REQ-031 SHALL cover MSB-first order: WIDTH=8, MSB_FIRST=1, load 8'hA5 -> sout sequence 1,0,1,0,0,1,0,1 over 8 cycles, sout_last on the 8th, then sout_valid=0.
REQ-032 SHALL cover LSB-first order: MSB_FIRST=0, load 8'h01 -> sout 1 then seven 0s; load_ready=0 throughout the frame.
REQ-033 SHALL cover enable stalls: en toggled 1,0,1,0,... during the frame -> each bit held for exactly two cycles; frame content unchanged.
REQ-034 SHALL cover back-to-back words: load_valid held at 1 with 8'hFF then 8'h00 -> second acceptance exactly 9 en-cycles after the first, with one idle cycle (sout_valid=0) between frames.
REQ-035 SHALL cover parity: with PISO_TX_PARITY_EN, load 8'h07 -> 8 data bits, then a 9th bit of 1 with sout_last=1.
